vector_line_stepper: RTL and testbench

//  Converts endpoint commands into a stream of DAC X/Y codes for the vector display. Draw lines
//  are stepped with Bresenham, one DAC LSB per step on the major axis; moves are blank jumps.

---
 rtl/vector_line_stepper.sv | 106 ++++++++++
 tb/tb_vector_line_stepper.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vector_line_stepper.sv
// vector_line_stepper: Bresenham line stepper driving registered X/Y DAC codes with beam blanking
module vector_line_stepper #(
  parameter int DAC_WIDTH    = 8,
  parameter int STEP_DWELL   = 0,
  parameter int CEASE_CYCLES = 3,
  parameter int MOVE_SETTLE  = 1000000,
  parameter int INVERT_Y     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DAC_WIDTH-1:0] cmd_x,
  input  logic [DAC_WIDTH-1:0] cmd_y,
  input  logic                 cmd_draw,
  input  logic                 abort,
  output logic [DAC_WIDTH-1:0] dac_x,
  output logic [DAC_WIDTH-1:0] dac_y,
  output logic                 beam_on,
  output logic                 busy,
  output logic                 done
);
  localparam int SW = DAC_WIDTH + 2;
  localparam int M1 = STEP_DWELL > CEASE_CYCLES ? STEP_DWELL : CEASE_CYCLES;
  localparam int MX = M1 > MOVE_SETTLE ? M1 : MOVE_SETTLE;
  localparam int CW = MX > 0 ? $clog2(MX + 1) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, STEP, DWELL, CEASE, SETTLE} state_t;
  state_t state, state_n;
  logic [DAC_WIDTH-1:0] px, py, tx, ty;
  logic draw, sx, sy, mx, my, at_target, accept, last;
  logic signed [SW-1:0] dx, dy, err, e2, adx, ady;
  logic [CW-1:0] cnt;
  logic [31:0] lim;
  assign cmd_ready = state == IDLE && rst_n;
  assign busy = state != IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign at_target = px == tx && py == ty;
  assign adx = tx >= px ? SW'(tx) - SW'(px) : SW'(px) - SW'(tx);
  assign ady = ty >= py ? SW'(ty) - SW'(py) : SW'(py) - SW'(ty);
  assign e2 = err <<< 1;
  assign mx = e2 > -dy;
  assign my = e2 < dx;
  // one shared counter serves dwell, cease and settle; it restarts on every state change
  assign lim = state == DWELL ? 32'(STEP_DWELL) : state == CEASE ? 32'(CEASE_CYCLES) : 32'(MOVE_SETTLE);
  assign last = 32'(cnt) + 32'd1 >= lim;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:          state_n = accept ? SETUP : IDLE;
      SETUP:         state_n = draw ? STEP : SETTLE;
      STEP:          state_n = at_target ? CEASE : (STEP_DWELL > 0 ? DWELL : STEP);
      DWELL:         state_n = last ? STEP : DWELL;
      CEASE, SETTLE: state_n = last ? IDLE : state;
      default:       state_n = IDLE;
    endcase
    if (abort && state != IDLE) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      px      <= '0;
      py      <= '0;
      tx      <= '0;
      ty      <= '0;
      draw    <= 1'b0;
      dx      <= '0;
      dy      <= '0;
      err     <= '0;
      sx      <= 1'b0;
      sy      <= 1'b0;
      cnt     <= '0;
      dac_x   <= '0;
      dac_y   <= {DAC_WIDTH{INVERT_Y != 0}};
      beam_on <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= state_n != state ? '0 : cnt + CW'(1);
      done  <= (state == CEASE || state == SETTLE) && last && !abort;
      dac_x <= px;
      dac_y <= INVERT_Y != 0 ? ~py : py;
      if (accept) begin
        tx   <= cmd_x;
        ty   <= cmd_y;
        draw <= cmd_draw;
      end
      if (abort && busy) beam_on <= 1'b0;
      else if (state == SETUP) begin
        dx      <= adx;
        dy      <= ady;
        err     <= adx - ady;
        sx      <= tx < px;
        sy      <= ty < py;
        beam_on <= draw;
        if (!draw) begin
          px <= tx;
          py <= ty;
        end
      end else if (state == STEP && !at_target) begin
        err <= err - (mx ? dy : SW'(0)) + (my ? dx : SW'(0));
        if (mx) px <= sx ? px - DAC_WIDTH'(1) : px + DAC_WIDTH'(1);
        if (my) py <= sy ? py - DAC_WIDTH'(1) : py + DAC_WIDTH'(1);
      end else if (state == CEASE && last) beam_on <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vector_line_stepper.sv
// tb_vector_line_stepper: directed checks of draw, move, dot, dwell, abort and reset behaviour
module tb_vector_line_stepper;
  logic clk = 0, rst_n = 0, cmd_valid = 0, cmd_valid1 = 0, cmd_draw = 0, abort = 0;
  logic [7:0] cmd_x = 0, cmd_y = 0;
  logic cmd_ready, beam_on, busy, done, cmd_ready1, beam_on1, busy1, done1;
  logic [7:0] dac_x, dac_y, dac_x1, dac_y1;
  int tests = 0, fails = 0;
  wire [18:0] obs = {dac_x, dac_y, beam_on, done, busy};
  always #5 clk = ~clk;
  vector_line_stepper #(.DAC_WIDTH(8), .STEP_DWELL(0), .CEASE_CYCLES(3), .MOVE_SETTLE(5), .INVERT_Y(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_draw(cmd_draw), .abort(abort), .dac_x(dac_x), .dac_y(dac_y), .beam_on(beam_on), .busy(busy), .done(done));
  vector_line_stepper #(.DAC_WIDTH(8), .STEP_DWELL(2), .CEASE_CYCLES(3), .MOVE_SETTLE(5), .INVERT_Y(1)) u_dwell (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_draw(cmd_draw), .abort(abort), .dac_x(dac_x1), .dac_y(dac_y1), .beam_on(beam_on1), .busy(busy1), .done(done1));

  function automatic logic [18:0] pk(input logic [7:0] x, y, input logic b, d, bs);
    return {x, y, b, d, bs};
  endfunction

  task automatic send(input logic u, input logic [7:0] x, y, input logic d);
    @(negedge clk);
    cmd_x = x; cmd_y = y; cmd_draw = d;
    if (u) cmd_valid1 = 1; else cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_valid1 = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    tests++; if ({obs, cmd_ready} !== {pk(0, 0, 0, 0, 0), 1'b0}) begin fails++; $display("FAIL reset_outputs got %h exp %h", {obs, cmd_ready}, {pk(0, 0, 0, 0, 0), 1'b0}); end
    tests++; if ({dac_y1, beam_on1, busy1} !== {8'hFF, 2'b00}) begin fails++; $display("FAIL reset_invert_y got %h exp %h", {dac_y1, beam_on1, busy1}, {8'hFF, 2'b00}); end
    rst_n = 1; #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_draw;
    logic [18:0] e [10];
    e = '{pk(0,0,0,0,1), pk(0,0,1,0,1), pk(0,0,1,0,1), pk(1,0,1,0,1), pk(2,1,1,0,1),
          pk(3,1,1,0,1), pk(3,1,1,0,1), pk(3,1,1,0,1), pk(3,1,0,1,0), pk(3,1,0,0,0)};
    send(0, 3, 1, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); tests++;
      if (obs !== e[k]) begin fails++; $display("FAIL draw_trace[%0d] got %h exp %h", k, obs, e[k]); end
    end
  endtask

  task automatic test_move;
    logic [18:0] e [8];
    e = '{pk(3,1,0,0,1), pk(3,1,0,0,1), pk(200,17,0,0,1), pk(200,17,0,0,1),
          pk(200,17,0,0,1), pk(200,17,0,0,1), pk(200,17,0,1,0), pk(200,17,0,0,0)};
    send(0, 200, 17, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); tests++;
      if (obs !== e[k]) begin fails++; $display("FAIL move_trace[%0d] got %h exp %h", k, obs, e[k]); end
    end
  endtask

  task automatic test_dot;
    logic [18:0] e [7];
    e = '{pk(10,10,0,0,1), pk(10,10,1,0,1), pk(10,10,1,0,1), pk(10,10,1,0,1),
          pk(10,10,1,0,1), pk(10,10,0,1,0), pk(10,10,0,0,0)};
    send(0, 10, 10, 0);
    repeat (8) @(negedge clk);
    tests++; if (obs !== pk(10,10,0,0,0)) begin fails++; $display("FAIL dot_premove got %h exp %h", obs, pk(10,10,0,0,0)); end
    send(0, 10, 10, 1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); tests++;
      if (obs !== e[k]) begin fails++; $display("FAIL dot_trace[%0d] got %h exp %h", k, obs, e[k]); end
    end
  endtask

  task automatic test_dwell_diag;
    int px = 255, py = 0, chg = 0, bad = 0, lastc = 0, first = -1, dcyc = -1;
    send(1, 255, 255, 0);
    repeat (8) @(negedge clk);
    tests++; if ({dac_x1, dac_y1, busy1} !== {8'd255, 8'd0, 1'b0}) begin fails++; $display("FAIL diag_premove got %h exp %h", {dac_x1, dac_y1, busy1}, {8'd255, 8'd0, 1'b0}); end
    send(1, 0, 0, 1);
    for (int c = 0; c < 2000 && dcyc < 0; c++) begin
      @(negedge clk);
      if (int'(dac_x1) != px || int'(dac_y1) != py) begin
        if (int'(dac_x1) != px - 1 || int'(dac_y1) != py + 1 || (chg > 0 && c - lastc != 3)) bad++;
        if (chg == 0) first = c;
        chg++; lastc = c; px = dac_x1; py = dac_y1;
      end
      if (done1) dcyc = c;
    end
    tests++; if (dcyc != 770) begin fails++; $display("FAIL diag_done_cycle got %0d exp 770", dcyc); end
    tests++; if (chg != 255) begin fails++; $display("FAIL diag_steps got %0d exp 255", chg); end
    tests++; if (bad != 0) begin fails++; $display("FAIL diag_step_shape got %0d exp 0", bad); end
    tests++; if (first != 3) begin fails++; $display("FAIL diag_first_visible got %0d exp 3", first); end
    tests++; if ({dac_x1, dac_y1, beam_on1} !== {8'd0, 8'hFF, 1'b0}) begin fails++; $display("FAIL diag_end got %h exp %h", {dac_x1, dac_y1, beam_on1}, {8'd0, 8'hFF, 1'b0}); end
  endtask

  task automatic test_abort;
    logic [18:0] e [8];
    int sawdone = 0;
    e = '{pk(14,10,0,0,1), pk(14,10,1,0,1), pk(14,10,1,0,1), pk(15,10,1,0,1),
          pk(16,10,1,0,1), pk(16,10,1,0,1), pk(16,10,1,0,1), pk(16,10,0,1,0)};
    send(0, 110, 10, 1);
    repeat (6) @(negedge clk);
    tests++; if ({dac_x, beam_on} !== {8'd13, 1'b1}) begin fails++; $display("FAIL abort_pre got %h exp %h", {dac_x, beam_on}, {8'd13, 1'b1}); end
    abort = 1;
    @(negedge clk); abort = 0;
    tests++; if ({dac_x, beam_on, cmd_ready, busy, done} !== {8'd14, 4'b0100}) begin fails++; $display("FAIL abort_next got %h exp %h", {dac_x, beam_on, cmd_ready, busy, done}, {8'd14, 4'b0100}); end
    repeat (4) begin @(negedge clk); if (done !== 1'b0 || dac_x !== 8'd14) sawdone++; end
    tests++; if (sawdone != 0) begin fails++; $display("FAIL abort_hold got %0d exp 0", sawdone); end
    abort = 1;
    @(negedge clk); abort = 0;
    tests++; if (obs !== pk(14,10,0,0,0)) begin fails++; $display("FAIL abort_idle got %h exp %h", obs, pk(14,10,0,0,0)); end
    cmd_x = 16; cmd_y = 10; cmd_draw = 1; cmd_valid = 1; abort = 1;
    @(posedge clk); #1;
    cmd_valid = 0; abort = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); tests++;
      if (obs !== e[k]) begin fails++; $display("FAIL abort_resume[%0d] got %h exp %h", k, obs, e[k]); end
    end
  endtask

  task automatic test_reset_midline;
    send(0, 116, 10, 1);
    cmd_x = 50; cmd_y = 60; cmd_draw = 0; cmd_valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); tests++;
      if ({cmd_ready, busy} !== 2'b01) begin fails++; $display("FAIL busy_block[%0d] got %b exp 01", k, {cmd_ready, busy}); end
    end
    @(negedge clk);
    tests++; if ({dac_x, dac_y, beam_on} !== {8'd19, 8'd10, 1'b1}) begin fails++; $display("FAIL midline_pos got %h exp %h", {dac_x, dac_y, beam_on}, {8'd19, 8'd10, 1'b1}); end
    rst_n = 0;
    @(negedge clk);
    tests++; if ({obs, cmd_ready} !== {pk(0,0,0,0,0), 1'b0}) begin fails++; $display("FAIL midline_reset got %h exp %h", {obs, cmd_ready}, {pk(0,0,0,0,0), 1'b0}); end
    tests++; if (dac_y1 !== 8'hFF) begin fails++; $display("FAIL midline_reset_inv got %h exp ff", dac_y1); end
    rst_n = 1;
    @(negedge clk); cmd_valid = 0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL held_accept got %b exp 1", busy); end
    @(negedge clk);
    tests++; if ({dac_x, dac_y} !== 16'h0000) begin fails++; $display("FAIL held_latency got %h exp 0000", {dac_x, dac_y}); end
    @(negedge clk);
    tests++; if ({dac_x, dac_y} !== {8'd50, 8'd60}) begin fails++; $display("FAIL held_target got %h exp %h", {dac_x, dac_y}, {8'd50, 8'd60}); end
    repeat (4) @(negedge clk);
    tests++; if ({done, busy, beam_on} !== 3'b100) begin fails++; $display("FAIL held_done got %b exp 100", {done, busy, beam_on}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_draw;
    test_move;
    test_dot;
    test_dwell_diag;
    test_abort;
    test_reset_midline;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
